id_fwd_stage: RTL and testbench

- Parametrised successor to the single-issue decode stage.
- Holds the IF->ID pipeline register and reads the external regfile.
- Resolves RAW hazards with an NFWD-source priority forwarding network plus load/mfc0-use interlock, and resolves branches in ID from forwarded operands.
- Tags exceptions, honours a pipeline flush from WB, and counts interlock cycles.
- Sits between IF and EX; instruction field decode comes from an external combinational decoder fed by ds_inst.

---
 rtl/id_fwd_stage.sv | 164 ++++++++++++++++
 tb/tb_id_fwd_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// Decode stage: IF->ID pipeline register, NFWD-source priority forwarding,
// load/mfc0-use interlock, branch resolution in ID, exception tagging.
module id_fwd_stage #(
  parameter int XLEN  = 32,
  parameter int NFWD  = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 fs_to_ds_valid,
  input  logic [31:0]          fs_pc,
  input  logic [31:0]          fs_inst,
  input  logic                 fs_ex,
  output logic                 ds_allowin,
  input  logic                 es_allowin,
  output logic                 ds_to_es_valid,
  output logic [31:0]          ds_pc,
  output logic [31:0]          ds_inst,
  input  logic                 dec_rs_used,
  input  logic                 dec_rt_used,
  input  logic [1:0]           dec_br_op,
  input  logic                 dec_jump,
  input  logic                 dec_ex,
  input  logic [4:0]           dec_excode,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [5*NFWD-1:0]    fwd_dest,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_ready,
  output logic [XLEN-1:0]      rs_value,
  output logic [XLEN-1:0]      rt_value,
  output logic                 ds_ex,
  output logic [4:0]           ds_excode,
  output logic                 br_taken,
  output logic [31:0]          br_target,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic             r_ds_valid;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic             r_fs_ex;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [4:0]       w_rs_addr;
  logic [4:0]       w_rt_addr;
  logic [XLEN-1:0]  w_rs_value;
  logic [XLEN-1:0]  w_rt_value;
  logic             w_rs_pending;
  logic             w_rt_pending;
  logic             w_stall;
  logic             w_ready_go;
  logic             w_allowin;
  logic             w_ex;
  logic             w_rs_eq;
  logic             w_taken_raw;
  logic [31:0]      w_pc4;
  logic [31:0]      w_br_off;
  logic [31:0]      w_j_target;
  logic [31:0]      w_target;

  assign w_rs_addr = r_inst[25:21];
  assign w_rt_addr = r_inst[20:16];

  // Scan oldest to youngest so the lowest-index hit overwrites the rest.
  always_comb begin
    w_rs_value   = rf_rdata1;
    w_rs_pending = 1'b0;
    w_rt_value   = rf_rdata2;
    w_rt_pending = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_we[i] && (fwd_dest[i*5 +: 5] == w_rs_addr) && (w_rs_addr != 5'd0)) begin
        w_rs_value   = fwd_data[i*XLEN +: XLEN];
        w_rs_pending = ~fwd_ready[i];
      end
      if (fwd_valid[i] && fwd_we[i] && (fwd_dest[i*5 +: 5] == w_rt_addr) && (w_rt_addr != 5'd0)) begin
        w_rt_value   = fwd_data[i*XLEN +: XLEN];
        w_rt_pending = ~fwd_ready[i];
      end
    end
  end

  assign w_stall    = r_ds_valid & ((dec_rs_used & w_rs_pending) | (dec_rt_used & w_rt_pending));
  assign w_ready_go = ~w_stall;
  assign w_allowin  = ~r_ds_valid | (w_ready_go & es_allowin);

  assign w_ex = r_fs_ex | dec_ex;

  assign w_pc4      = r_pc + 32'd4;
  assign w_br_off   = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_j_target = {w_pc4[31:28], r_inst[25:0], 2'b00};
  assign w_rs_eq    = (w_rs_value == w_rt_value);

  always_comb begin
    w_taken_raw = dec_jump;
    w_target    = w_j_target;
    case (dec_br_op)
      2'b01: begin
        w_taken_raw = dec_jump | w_rs_eq;
        w_target    = w_pc4 + w_br_off;
      end
      2'b10: begin
        w_taken_raw = dec_jump | ~w_rs_eq;
        w_target    = w_pc4 + w_br_off;
      end
      2'b11: begin
        w_taken_raw = 1'b1;
        w_target    = w_rs_value[31:0];
      end
      default: ;
    endcase
  end

  // A flush drops both the held instruction and one arriving in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ds_valid <= 1'b0;
    end else if (flush) begin
      r_ds_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ds_valid <= fs_to_ds_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc    <= 32'd0;
      r_inst  <= 32'd0;
      r_fs_ex <= 1'b0;
    end else if (fs_to_ds_valid && w_allowin) begin
      r_pc    <= fs_pc;
      r_inst  <= fs_inst;
      r_fs_ex <= fs_ex;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ds_allowin     = w_allowin;
  assign ds_to_es_valid = r_ds_valid & w_ready_go & ~flush;
  assign ds_pc          = r_pc;
  assign ds_inst        = r_inst;
  assign rf_raddr1      = w_rs_addr;
  assign rf_raddr2      = w_rt_addr;
  assign rs_value       = w_rs_value;
  assign rt_value       = w_rt_value;
  assign ds_ex          = w_ex;
  assign ds_excode      = r_fs_ex ? 5'h04 : (dec_ex ? dec_excode : 5'h00);
  assign br_taken       = r_ds_valid & w_ready_go & w_taken_raw & ~w_ex & ~flush;
  assign br_target      = w_target;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Scoreboard bench for id_fwd_stage: expectations queued when stimulus is
// driven, popped and compared at the following falling edge.
module tb_id_fwd_stage;

  localparam int XLEN  = 32;
  localparam int NFWD  = 3;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 flush;
  logic                 fs_to_ds_valid;
  logic [31:0]          fs_pc;
  logic [31:0]          fs_inst;
  logic                 fs_ex;
  logic                 ds_allowin;
  logic                 es_allowin;
  logic                 ds_to_es_valid;
  logic [31:0]          ds_pc;
  logic [31:0]          ds_inst;
  logic                 dec_rs_used;
  logic                 dec_rt_used;
  logic [1:0]           dec_br_op;
  logic                 dec_jump;
  logic                 dec_ex;
  logic [4:0]           dec_excode;
  logic [4:0]           rf_raddr1;
  logic [4:0]           rf_raddr2;
  logic [XLEN-1:0]      rf_rdata1;
  logic [XLEN-1:0]      rf_rdata2;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_we;
  logic [5*NFWD-1:0]    fwd_dest;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_ready;
  logic [XLEN-1:0]      rs_value;
  logic [XLEN-1:0]      rt_value;
  logic                 ds_ex;
  logic [4:0]           ds_excode;
  logic                 br_taken;
  logic [31:0]          br_target;
  logic [CNT_W-1:0]     stall_cnt;

  typedef struct {
    logic        vld;
    logic        allowin;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        br;
    logic [31:0] tgt;
    logic        ex;
    logic [4:0]  code;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'd0;

  id_fwd_stage #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_ex(fs_ex),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .ds_pc(ds_pc), .ds_inst(ds_inst),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_br_op(dec_br_op),
    .dec_jump(dec_jump), .dec_ex(dec_ex), .dec_excode(dec_excode),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_ready(fwd_ready), .rs_value(rs_value), .rt_value(rt_value),
    .ds_ex(ds_ex), .ds_excode(ds_excode), .br_taken(br_taken), .br_target(br_target),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearFwd();
    fwd_valid = '0;
    fwd_we    = '0;
    fwd_dest  = '0;
    fwd_data  = '0;
    fwd_ready = '0;
  endtask

  task automatic setFwd(input int idx, input logic v, input logic we, input logic [4:0] d,
                        input logic [31:0] data, input logic rdy);
    fwd_valid[idx]          = v;
    fwd_we[idx]             = we;
    fwd_dest[idx*5 +: 5]    = d;
    fwd_data[idx*XLEN +: XLEN] = data;
    fwd_ready[idx]          = rdy;
  endtask

  // Loads one instruction into ID; returns one time unit after the loading edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic ex);
    clearFwd();
    es_allowin     = 1'b1;
    dec_rs_used    = 1'b0;
    dec_rt_used    = 1'b0;
    dec_br_op      = 2'b00;
    dec_jump       = 1'b0;
    dec_ex         = 1'b0;
    dec_excode     = 5'd0;
    fs_pc          = pc;
    fs_inst        = inst;
    fs_ex          = ex;
    fs_to_ds_valid = 1'b1;
    @(posedge clk);
    #1;
    fs_to_ds_valid = 1'b0;
    fs_ex          = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    resetn = 1'b0;
    sb.push_back('{vld:1'b0, allowin:1'b1, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0,
                   ex:1'b0, code:5'd0, cnt:16'd0});
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL reset_valid: got %b want %b", ds_to_es_valid, e.vld); end
    checks++; if (ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL reset_allowin: got %b want %b", ds_allowin, e.allowin); end
    checks++; if (br_taken !== e.br) begin failures++; $display("[TB] FAIL reset_br: got %b want %b", br_taken, e.br); end
    checks++; if (ds_pc !== 32'd0) begin failures++; $display("[TB] FAIL reset_pc: got %h want 0", ds_pc); end
    checks++; if (ds_inst !== 32'd0) begin failures++; $display("[TB] FAIL reset_inst: got %h want 0", ds_inst); end
    checks++; if (ds_ex !== e.ex || ds_excode !== e.code) begin failures++; $display("[TB] FAIL reset_ex: got %b/%h want %b/%h", ds_ex, ds_excode, e.ex, e.code); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL reset_cnt: got %0d want %0d", stall_cnt, e.cnt); end
    #1 resetn = 1'b1;
    nextCycle();
  endtask

  task automatic test_fwd_priority();
    exp_t e;
    exp_t pat[4];
    applyStimulus(32'h400, {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h21}, 1'b0);
    es_allowin  = 1'b0;
    dec_rs_used = 1'b1;
    dec_rt_used = 1'b1;
    pat[0] = '{vld:1'b1, allowin:1'b0, rs:32'h11, rt:32'hBBBB_0002, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt};
    pat[1] = '{vld:1'b1, allowin:1'b0, rs:32'h22, rt:32'hBBBB_0002, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt};
    pat[2] = '{vld:1'b1, allowin:1'b0, rs:32'h33, rt:32'hBBBB_0002, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt};
    pat[3] = '{vld:1'b1, allowin:1'b0, rs:32'h33, rt:32'h66, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt};
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: begin setFwd(0, 1'b1, 1'b1, 5'd5, 32'h11, 1'b1); setFwd(2, 1'b1, 1'b1, 5'd5, 32'h22, 1'b1); end
        1: setFwd(0, 1'b0, 1'b1, 5'd5, 32'h11, 1'b1);
        2: begin setFwd(1, 1'b1, 1'b1, 5'd5, 32'h33, 1'b1); setFwd(0, 1'b1, 1'b0, 5'd5, 32'h11, 1'b1); end
        default: setFwd(2, 1'b1, 1'b1, 5'd6, 32'h66, 1'b1);
      endcase
      sb.push_back(pat[p]);
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (rs_value !== e.rs) begin failures++; $display("[TB] FAIL fwd_rs[%0d]: got %h want %h", p, rs_value, e.rs); end
      checks++; if (rt_value !== e.rt) begin failures++; $display("[TB] FAIL fwd_rt[%0d]: got %h want %h", p, rt_value, e.rt); end
      checks++; if (ds_to_es_valid !== e.vld || ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL fwd_hs[%0d]: got %b%b want %b%b", p, ds_to_es_valid, ds_allowin, e.vld, e.allowin); end
      nextCycle();
    end
    // r0 must bypass the network even when a not-ready source names it
    applyStimulus(32'h404, {6'h00, 5'd0, 5'd6, 5'd7, 5'd0, 6'h21}, 1'b0);
    es_allowin  = 1'b0;
    dec_rs_used = 1'b1;
    setFwd(0, 1'b1, 1'b1, 5'd0, 32'h99, 1'b0);
    sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'hAAAA_0001, rt:32'hBBBB_0002, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rs_value !== e.rs) begin failures++; $display("[TB] FAIL fwd_r0: got %h want %h", rs_value, e.rs); end
    checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL fwd_r0_valid: got %b want %b", ds_to_es_valid, e.vld); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL fwd_cnt: got %0d want %0d", stall_cnt, e.cnt); end
  endtask

  task automatic test_load_use();
    exp_t e;
    applyStimulus(32'h500, {6'h00, 5'd4, 5'd3, 5'd8, 5'd0, 6'h21}, 1'b0);
    dec_rs_used = 1'b1;
    dec_rt_used = 1'b1;
    setFwd(0, 1'b1, 1'b1, 5'd3, 32'h0, 1'b0);
    sb.push_back('{vld:1'b0, allowin:1'b0, rs:32'hAAAA_0001, rt:32'h0, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL lu_valid: got %b want %b", ds_to_es_valid, e.vld); end
    checks++; if (ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL lu_allowin: got %b want %b", ds_allowin, e.allowin); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL lu_cnt0: got %0d want %0d", stall_cnt, e.cnt); end
    @(posedge clk);
    exp_cnt = exp_cnt + 16'd1;
    #1;
    setFwd(0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
    sb.push_back('{vld:1'b1, allowin:1'b1, rs:32'hAAAA_0001, rt:32'hDEADBEEF, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (rt_value !== e.rt) begin failures++; $display("[TB] FAIL lu_rt: got %h want %h", rt_value, e.rt); end
    checks++; if (ds_to_es_valid !== e.vld || ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL lu_issue: got %b%b want %b%b", ds_to_es_valid, ds_allowin, e.vld, e.allowin); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL lu_cnt1: got %0d want %0d", stall_cnt, e.cnt); end
    nextCycle();
    clearFwd();
    sb.push_back('{vld:1'b0, allowin:1'b1, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld || ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL lu_drain: got %b%b want %b%b", ds_to_es_valid, ds_allowin, e.vld, e.allowin); end
  endtask

  task automatic test_branch();
    exp_t e;
    applyStimulus(32'h1000, {6'h04, 5'd1, 5'd2, 16'h0004}, 1'b0);
    es_allowin  = 1'b0;
    dec_rs_used = 1'b1;
    dec_rt_used = 1'b1;
    for (int p = 0; p < 6; p++) begin
      case (p)
        0: begin
          dec_br_op = 2'b01;
          setFwd(0, 1'b1, 1'b1, 5'd1, 32'h55, 1'b1);
          setFwd(2, 1'b1, 1'b1, 5'd2, 32'h55, 1'b1);
          sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'h55, rt:32'h55, br:1'b1, tgt:32'h1014, ex:1'b0, code:5'd0, cnt:exp_cnt});
        end
        1: sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'h55, rt:32'h55, br:1'b1, tgt:32'h1014, ex:1'b0, code:5'd0, cnt:exp_cnt});
        2: begin
          setFwd(2, 1'b1, 1'b1, 5'd2, 32'h56, 1'b1);
          sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'h55, rt:32'h56, br:1'b0, tgt:32'h1014, ex:1'b0, code:5'd0, cnt:exp_cnt});
        end
        3: begin
          dec_br_op = 2'b10;
          sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'h55, rt:32'h56, br:1'b1, tgt:32'h1014, ex:1'b0, code:5'd0, cnt:exp_cnt});
        end
        4: begin
          dec_br_op = 2'b11;
          sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'h55, rt:32'h56, br:1'b1, tgt:32'h55, ex:1'b0, code:5'd0, cnt:exp_cnt});
        end
        default: begin
          setFwd(0, 1'b1, 1'b1, 5'd1, 32'h55, 1'b0);
          sb.push_back('{vld:1'b0, allowin:1'b0, rs:32'h55, rt:32'h56, br:1'b0, tgt:32'h55, ex:1'b0, code:5'd0, cnt:exp_cnt});
        end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (br_taken !== e.br) begin failures++; $display("[TB] FAIL br_taken[%0d]: got %b want %b", p, br_taken, e.br); end
      checks++; if (br_target !== e.tgt) begin failures++; $display("[TB] FAIL br_target[%0d]: got %h want %h", p, br_target, e.tgt); end
      checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL br_valid[%0d]: got %b want %b", p, ds_to_es_valid, e.vld); end
      @(posedge clk);
      if (p == 5) exp_cnt = exp_cnt + 16'd1;
      #1;
    end
    applyStimulus(32'h2000, {6'h05, 5'd1, 5'd2, 16'hFFFC}, 1'b0);
    es_allowin  = 1'b0;
    dec_rs_used = 1'b1;
    dec_rt_used = 1'b1;
    dec_br_op   = 2'b10;
    sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'hAAAA_0001, rt:32'hBBBB_0002, br:1'b1, tgt:32'h1FF4, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (br_taken !== e.br) begin failures++; $display("[TB] FAIL br_neg_taken: got %b want %b", br_taken, e.br); end
    checks++; if (br_target !== e.tgt) begin failures++; $display("[TB] FAIL br_neg_target: got %h want %h", br_target, e.tgt); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL br_cnt: got %0d want %0d", stall_cnt, e.cnt); end
  endtask

  task automatic test_jump_flush();
    exp_t e;
    applyStimulus(32'h2000_0010, {6'h03, 26'h0123456}, 1'b0);
    es_allowin = 1'b0;
    dec_jump   = 1'b1;
    sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'd0, rt:32'd0, br:1'b1, tgt:32'h2048_D158, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (br_taken !== e.br || br_target !== e.tgt) begin failures++; $display("[TB] FAIL jal: got %b/%h want %b/%h", br_taken, br_target, e.br, e.tgt); end
    nextCycle();
    flush = 1'b1;
    sb.push_back('{vld:1'b0, allowin:1'b0, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'h2048_D158, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL flush_valid: got %b want %b", ds_to_es_valid, e.vld); end
    checks++; if (br_taken !== e.br) begin failures++; $display("[TB] FAIL flush_br: got %b want %b", br_taken, e.br); end
    nextCycle();
    flush = 1'b0;
    sb.push_back('{vld:1'b0, allowin:1'b1, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld || br_taken !== e.br || ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL flush_after: got %b%b%b want %b%b%b", ds_to_es_valid, br_taken, ds_allowin, e.vld, e.br, e.allowin); end
    fs_pc          = 32'h600;
    fs_inst        = 32'h0;
    fs_to_ds_valid = 1'b1;
    flush          = 1'b1;
    nextCycle();
    fs_to_ds_valid = 1'b0;
    flush          = 1'b0;
    sb.push_back('{vld:1'b0, allowin:1'b1, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL flush_discard: got %b want %b", ds_to_es_valid, e.vld); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL flush_cnt: got %0d want %0d", stall_cnt, e.cnt); end
  endtask

  task automatic test_exception();
    exp_t e;
    for (int p = 0; p < 3; p++) begin
      if (p < 2) begin
        applyStimulus(32'h3000 + 32'(p*4), 32'h0000_000C, (p == 0));
        es_allowin = 1'b0;
      end
      dec_jump   = 1'b1;
      dec_ex     = (p < 2);
      dec_excode = 5'd8;
      case (p)
        0: sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b1, code:5'h04, cnt:exp_cnt});
        1: sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b1, code:5'h08, cnt:exp_cnt});
        default: sb.push_back('{vld:1'b1, allowin:1'b0, rs:32'd0, rt:32'd0, br:1'b1, tgt:32'h30, ex:1'b0, code:5'h00, cnt:exp_cnt});
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (ds_ex !== e.ex) begin failures++; $display("[TB] FAIL exc_flag[%0d]: got %b want %b", p, ds_ex, e.ex); end
      checks++; if (ds_excode !== e.code) begin failures++; $display("[TB] FAIL exc_code[%0d]: got %h want %h", p, ds_excode, e.code); end
      checks++; if (br_taken !== e.br) begin failures++; $display("[TB] FAIL exc_br[%0d]: got %b want %b", p, br_taken, e.br); end
      checks++; if (ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL exc_valid[%0d]: got %b want %b", p, ds_to_es_valid, e.vld); end
      if (p == 2) begin
        checks++; if (br_target !== e.tgt) begin failures++; $display("[TB] FAIL exc_target: got %h want %h", br_target, e.tgt); end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    applyStimulus(32'h4000, {6'h00, 5'd3, 5'd0, 5'd9, 5'd0, 6'h21}, 1'b0);
    dec_rs_used = 1'b1;
    dec_br_op   = 2'b01;
    setFwd(0, 1'b1, 1'b1, 5'd3, 32'h0, 1'b0);
    sb.push_back('{vld:1'b0, allowin:1'b0, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (ds_to_es_valid !== e.vld || br_taken !== e.br) begin failures++; $display("[TB] FAIL stall_pre: got %b%b want %b%b", ds_to_es_valid, br_taken, e.vld, e.br); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL stall_pre_cnt: got %0d want %0d", stall_cnt, e.cnt); end
    @(posedge clk);
    exp_cnt = exp_cnt + 16'd1;
    #1;
    checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("[TB] FAIL stall_cnt_inc: got %0d want %0d", stall_cnt, exp_cnt); end
    #1 resetn = 1'b0;
    exp_cnt = 16'd0;
    sb.push_back('{vld:1'b0, allowin:1'b1, rs:32'd0, rt:32'd0, br:1'b0, tgt:32'd0, ex:1'b0, code:5'd0, cnt:exp_cnt});
    #1;
    e = sb.pop_front();
    checks++; if (ds_allowin !== e.allowin) begin failures++; $display("[TB] FAIL arst_allowin: got %b want %b", ds_allowin, e.allowin); end
    checks++; if (stall_cnt !== e.cnt) begin failures++; $display("[TB] FAIL arst_cnt: got %0d want %0d", stall_cnt, e.cnt); end
    checks++; if (br_taken !== e.br || ds_to_es_valid !== e.vld) begin failures++; $display("[TB] FAIL arst_out: got %b%b want %b%b", br_taken, ds_to_es_valid, e.br, e.vld); end
    checks++; if (ds_pc !== 32'd0) begin failures++; $display("[TB] FAIL arst_pc: got %h want 0", ds_pc); end
    #1 resetn = 1'b1;
    clearFwd();
  endtask

  initial begin
    resetn         = 1'b0;
    flush          = 1'b0;
    fs_to_ds_valid = 1'b0;
    fs_pc          = 32'd0;
    fs_inst        = 32'd0;
    fs_ex          = 1'b0;
    es_allowin     = 1'b1;
    dec_rs_used    = 1'b0;
    dec_rt_used    = 1'b0;
    dec_br_op      = 2'b00;
    dec_jump       = 1'b0;
    dec_ex         = 1'b0;
    dec_excode     = 5'd0;
    rf_rdata1      = 32'hAAAA_0001;
    rf_rdata2      = 32'hBBBB_0002;
    clearFwd();
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_branch();
    test_jump_flush();
    test_exception();
    test_reset_mid_stall();
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
